// File: rtl/uart_sr_9bit_pkg.sv
// Shared UART constants for the receive datapath.
//   DATA_BITS     : payload bits per frame
//   FRAME_SR_BITS : bits captured by the receive shift register (data + stop)
//   UART_IDLE     : line level when idle (mark)
package uart_sr_9bit_pkg;

    localparam int unsigned DATA_BITS     = 8;
    localparam int unsigned FRAME_SR_BITS = 9;
    localparam logic        UART_IDLE     = 1'b1;

endpackage

// File: rtl/flex_stp_sr.sv
// Generic serial-to-parallel shift register.
// Parameters:
//   NUM_BITS  : register width
//   SHIFT_MSB : 1 = shift toward MSB (new bit at LSB), 0 = shift toward LSB (new bit at MSB)
// Ports:
//   clk          : system clock, rising edge
//   n_rst        : asynchronous active-low reset, loads all ones
//   shift_enable : one shift per rising edge while high
//   serial_in    : serial input bit
//   parallel_out : register contents
module flex_stp_sr #(
    parameter int unsigned NUM_BITS  = 4,
    parameter bit          SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                serial_in,
    output logic [NUM_BITS-1:0] parallel_out
);

    logic [NUM_BITS-1:0] sr_q;
    logic [NUM_BITS-1:0] sr_d;
    logic [NUM_BITS-1:0] shifted;

    // Separate single-bit case keeps the slices below legal for NUM_BITS == 1.
    if (NUM_BITS == 1) begin : g_single
        assign shifted = serial_in;
    end else if (SHIFT_MSB) begin : g_to_msb
        assign shifted = {sr_q[NUM_BITS-2:0], serial_in};
    end else begin : g_to_lsb
        assign shifted = {serial_in, sr_q[NUM_BITS-1:1]};
    end

    always_comb begin
        sr_d = sr_q;
        if (shift_enable) begin
            sr_d = shifted;
        end
    end

    // All-ones reset matches an idle (mark) serial line.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr_q <= '1;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign parallel_out = sr_q;

endmodule

// File: rtl/uart_sr_9bit.sv
// UART receive shift register: captures 8 data bits and the stop bit LSB-first.
// Ports:
//   clk          : system clock, rising edge
//   n_rst        : asynchronous active-low reset, outputs return to idle (all ones)
//   shift_strobe : one shift per rising edge while high (once per bit period)
//   serial_in    : synchronized RX bit
//   packet_data  : received byte, bit 0 = first data bit received
//   stop_bit     : most recently received bit (stop bit once the frame is complete)
module uart_sr_9bit
    import uart_sr_9bit_pkg::*;
(
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 shift_strobe,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] packet_data,
    output logic                 stop_bit
);

    logic [FRAME_SR_BITS-1:0] frame;

    // New bits enter at the MSB so the first data bit ends up in bit 0 after a full frame.
    flex_stp_sr #(
        .NUM_BITS  (FRAME_SR_BITS),
        .SHIFT_MSB (1'b0)
    ) u_sr (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (shift_strobe),
        .serial_in    (serial_in),
        .parallel_out (frame)
    );

    assign stop_bit    = frame[FRAME_SR_BITS-1];
    assign packet_data = frame[DATA_BITS-1:0];

endmodule

// File: tb/tb_uart_sr_9bit.sv
module tb_uart_sr_9bit;

    logic       clk;
    logic       n_rst;
    logic       shift_strobe;
    logic       serial_in;
    logic [7:0] packet_data;
    logic       stop_bit;

    int checks;
    int errors;

    // Scoreboard of expected {stop_bit, packet_data} values.
    logic [8:0] exp_q[$];

    uart_sr_9bit dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_strobe (shift_strobe),
        .serial_in    (serial_in),
        .packet_data  (packet_data),
        .stop_bit     (stop_bit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [8:0] exp;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            exp = exp_q.pop_front();
            check(tag, {stop_bit, packet_data}, exp);
        end
    endtask

    // Shift bits[0..n-1] in order, with 'gap' idle cycles after each strobe.
    // stop_bit must show each bit right after its strobed edge.
    task automatic shift_bits(input logic [8:0] bits, input int n, input int gap, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            shift_strobe = 1'b1;
            serial_in    = bits[i];
            @(posedge clk);
            #1;
            check({tag, "_latency"}, {8'h00, stop_bit}, {8'h00, bits[i]});
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                shift_strobe = 1'b0;
                serial_in    = ~serial_in;
                @(posedge clk);
            end
        end
        @(negedge clk);
        shift_strobe = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input int gap,
                              input string tag);
        exp_q.push_back({stop, data});
        shift_bits({stop, data}, 9, gap, tag);
        pop_check(tag);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        n_rst        = 1'b1;
        shift_strobe = 1'b0;
        serial_in    = 1'b0;

        // Reset asserted between edges must act immediately and hold across clocks.
        #2;
        n_rst = 1'b0;
        #1;
        check("reset_async", {stop_bit, packet_data}, 9'h1FF);
        @(posedge clk);
        #1;
        check("reset_hold1", {stop_bit, packet_data}, 9'h1FF);
        @(posedge clk);
        #1;
        check("reset_hold2", {stop_bit, packet_data}, 9'h1FF);
        @(negedge clk);
        n_rst = 1'b1;

        send_frame(8'h00, 1'b1, 0, "zero_byte");
        send_frame(8'hA5, 1'b1, 0, "a5_b2b");

        // Strobe low: serial_in toggles but nothing moves.
        exp_q.push_back(9'h1A5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            serial_in = ~serial_in;
        end
        @(negedge clk);
        pop_check("hold");

        send_frame(8'h5A, 1'b0, 0, "5a_b2b");
        send_frame(8'hA5, 1'b1, 2, "a5_gapped");

        // Four zeros shifted into 1_1010_0101 -> 0_0001_1010.
        exp_q.push_back(9'h01A);
        shift_bits(9'h000, 4, 0, "partial");
        pop_check("partial");

        // Asynchronous reset pulse mid-low-phase, no clock edge involved.
        #2;
        n_rst = 1'b0;
        #1;
        check("midframe_reset", {stop_bit, packet_data}, 9'h1FF);
        n_rst = 1'b1;

        send_frame(8'h3C, 1'b0, 0, "3c_stop0");

        // Extra strobes keep shifting: one more '1' after 0_0011_1100.
        exp_q.push_back(9'h11E);
        shift_bits(9'h001, 1, 0, "extra");
        pop_check("extra");

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
